rc4_decrypt_loop: RTL and testbench
===================================

Name: rc4_decrypt_loop

Overview:
- Third loop of the RC4 key-search datapath: the RC4 PRGA/decrypt stage.
- Starts after loop 2 (key scheduling) has permuted S memory. For each message byte k it generates the keystream byte, XORs it with the encrypted ROM byte, writes the result to the decrypted RAM and hands the character to check_char.
- Advances to the next byte only when check_char accepts the character. Aborts when check_char requests start_over.

Parameters:
- MSG_LEN, 32, number of message bytes processed per key attempt (1..32).
- K_W, 6, width of the char_count index; must hold MSG_LEN.

Ports:
- clok  in  1  system clock
- resetm  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse from loop 2 done; begins decryption
- start_over  in  1  abort from check_char; return to IDLE
- char_ack  in  1  check_char accepted current char (matched_cont); advance k
- s_addr  out  8  S memory address
- s_wrdata  out  8  S memory write data
- s_wren  out  1  S memory write enable
- s_rddata  in  8  S memory read data, valid 1 cycle after address
- rom_addr  out  5  encrypted ROM address
- rom_rddata  in  8  encrypted ROM data, valid 1 cycle after address
- dec_addr  out  5  decrypted RAM address
- dec_wrdata  out  8  decrypted RAM write data
- dec_wren  out  1  decrypted RAM write enable
- char_out  out  8  decrypted character to check_char
- new_char  out  1  one-cycle pulse, char_out valid
- char_count  out  K_W  current k (wired to check_char char_count)
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  high in DONE, all MSG_LEN bytes accepted
- reject  out  1  early-reject pulse (see Optional Feature)

Behaviour:
- Reset (synchronous, resetm=1 at clok edge): state=IDLE. i, j, k, si, sj, f, char_out, char_count and all addresses = 0. s_wren, dec_wren, new_char, busy, done, reject = 0. Reset overrides all other inputs.
- Arithmetic: i, j, S indices are 8-bit and wrap mod 256. k runs 0..MSG_LEN-1.
- IDLE: waits for start. On start, set i=j=k=0 and go to INC_I.
- Per-character sequence, one state per cycle:
  - INC_I: i<=i+1; s_addr=i+1.
  - WAIT_SI.
  - READ_SI: si<=s_rddata; j<=j+s_rddata; s_addr=j+s_rddata.
  - WAIT_SJ.
  - READ_SJ: sj<=s_rddata.
  - WR_I: S[i]<=sj (s_wren=1).
  - WR_J: S[j]<=si (s_wren=1).
  - ADDR_F: s_addr=si+sj; rom_addr=k.
  - WAIT_F.
  - READ_F: f<=s_rddata; latch rom_rddata.
  - WR_DEC: dec_addr=k; dec_wrdata=f^enc; dec_wren=1; char_out<=f^enc.
  - EMIT: new_char=1 for exactly this cycle.
  - WAIT_ACK.
- Latency: 12 cycles from INC_I to the new_char pulse, 13 cycles from start to the first new_char.
- When i==j, WR_I and WR_J both write the same location with the same value. This is legal and must leave S unchanged.
- WAIT_ACK:
  - char_ack: k<=k+1. If k+1==MSG_LEN go to DONE, else go to INC_I.
  - start_over: go to IDLE; i, j, k and char_count cleared.
  - char_ack and start_over in the same cycle: start_over wins.
- start_over in any busy state aborts to IDLE in the next cycle. No further S or dec writes occur after the abort cycle.
- start received while busy is ignored. start in DONE restarts from k=0.
- char_count mirrors k at all times. It is updated in the same cycle k changes.
- DONE: done=1 and holds until start, start_over or reset.
- Control outputs (s_wren, dec_wren, new_char) are registered and never glitch between states.

Optional Feature:
- Macro: RC4_EARLY_REJECT_EN.
- Defined: in WR_DEC, if char_out is not in 97..122 and not 32, the block does the following:
  - still writes the dec RAM;
  - pulses reject for 1 cycle in place of new_char;
  - returns to IDLE without waiting for char_ack.
  - This saves the check_char round trip.
- Undefined: reject is tied to 0, and every character goes through EMIT/WAIT_ACK.

Test Plan:
- Identity S (S[x]=x), enc={0x63,0x67,0x64,...}, start -> new_char 13 cycles after start. char_out 0x61, 0x62, 0x63 for k=0,1,2 (keystream 2,5,7). dec RAM[0..2]="abc". After WR_J of k=1, S[2]=3 and S[3]=2.
- Same setup, char_ack each EMIT, MSG_LEN=32 -> 32 new_char pulses; char_count walks 0..31; done=1 after 32nd ack; busy=0.
- start_over in WAIT_ACK at k=5 -> IDLE next cycle; char_count=0; no dec_wren after abort. A new start gives char_out 0x61 at k=0 again (S memory reloaded by bench).
- char_ack and start_over in the same cycle -> IDLE; k not incremented; done stays 0.
- resetm asserted in WR_I mid-character -> all outputs 0 next cycle; s_wren 0; state IDLE; start ignored while resetm=1.
- RC4_EARLY_REJECT_EN defined, enc[0]=0x00 with identity S (char 0x02) -> reject pulse in the cycle new_char would occur; new_char stays 0; IDLE next cycle; dec RAM[0]=0x02.

Source files
------------

// File: rtl/rc4_decrypt_loop.sv
// RC4 PRGA/decrypt loop: generates the keystream from the permuted S memory,
// decrypts the ROM message byte by byte and hands each character to check_char.
// Optional early reject of non-lowercase/non-space characters: RC4_EARLY_REJECT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start from the key-scheduling loop
// INC_I    | i <= i+1, present S[i] address
// WAIT_SI  | S memory read latency
// READ_SI  | capture S[i], j <= j+S[i], present S[j] address
// WAIT_SJ  | S memory read latency
// READ_SJ  | capture S[j]
// WR_I     | write S[i] <= S[j]
// WR_J     | write S[j] <= S[i]
// ADDR_F   | present S[S[i]+S[j]] and ROM[k] addresses
// WAIT_F   | S/ROM read latency
// READ_F   | capture keystream byte f and encrypted byte
// WR_DEC   | write decrypted byte to RAM, latch char_out
// EMIT     | raise new_char (or reject) for one cycle
// WAIT_ACK | wait for check_char to accept the character
// DONE     | all MSG_LEN characters accepted
module rc4_decrypt_loop #(
  parameter int MSG_LEN = 32,
  parameter int K_W     = 6
) (
  input  logic           clok,
  input  logic           resetm,
  input  logic           start,
  input  logic           start_over,
  input  logic           char_ack,
  output logic [7:0]     s_addr,
  output logic [7:0]     s_wrdata,
  output logic           s_wren,
  input  logic [7:0]     s_rddata,
  output logic [4:0]     rom_addr,
  input  logic [7:0]     rom_rddata,
  output logic [4:0]     dec_addr,
  output logic [7:0]     dec_wrdata,
  output logic           dec_wren,
  output logic [7:0]     char_out,
  output logic           new_char,
  output logic [K_W-1:0] char_count,
  output logic           busy,
  output logic           done,
  output logic           reject
);

  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    WAIT_SI,
    READ_SI,
    WAIT_SJ,
    READ_SJ,
    WR_I,
    WR_J,
    ADDR_F,
    WAIT_F,
    READ_F,
    WR_DEC,
    EMIT,
    WAIT_ACK,
    DONE
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [7:0]     i;
  logic [7:0]     j;
  logic [7:0]     si;
  logic [7:0]     sj;
  logic [7:0]     f;
  logic [7:0]     enc;
  logic [K_W-1:0] k;
  logic [7:0]     dec_byte;
  logic           in_busy;
  logic           last_char;

  assign in_busy    = (state != IDLE) && (state != DONE);
  assign busy       = in_busy;
  assign done       = (state == DONE);
  assign char_count = k;
  assign dec_byte   = f ^ enc;
  assign last_char  = (k == K_W'(MSG_LEN - 1));

`ifdef RC4_EARLY_REJECT_EN
  logic rej_pend;
  logic reject_q;
  logic char_bad;

  assign char_bad = !(((dec_byte >= 8'd97) && (dec_byte <= 8'd122)) || (dec_byte == 8'd32));
  assign reject   = reject_q;
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clok) begin
    if (resetm) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = INC_I;
      INC_I:    state_nx = WAIT_SI;
      WAIT_SI:  state_nx = READ_SI;
      READ_SI:  state_nx = WAIT_SJ;
      WAIT_SJ:  state_nx = READ_SJ;
      READ_SJ:  state_nx = WR_I;
      WR_I:     state_nx = WR_J;
      WR_J:     state_nx = ADDR_F;
      ADDR_F:   state_nx = WAIT_F;
      WAIT_F:   state_nx = READ_F;
      READ_F:   state_nx = WR_DEC;
      WR_DEC:   state_nx = EMIT;
      EMIT: begin
`ifdef RC4_EARLY_REJECT_EN
        state_nx = rej_pend ? IDLE : WAIT_ACK;
`else
        state_nx = WAIT_ACK;
`endif
      end
      WAIT_ACK: if (char_ack) state_nx = last_char ? DONE : INC_I;
      DONE:     if (start) state_nx = INC_I;
      default:  state_nx = IDLE;
    endcase
    // abort beats everything, including a simultaneous char_ack or start
    if (start_over) state_nx = IDLE;
  end

  always_ff @(posedge clok) begin
    if (resetm) begin
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= '0;
      si         <= 8'd0;
      sj         <= 8'd0;
      f          <= 8'd0;
      enc        <= 8'd0;
      char_out   <= 8'd0;
      s_addr     <= 8'd0;
      s_wrdata   <= 8'd0;
      s_wren     <= 1'b0;
      rom_addr   <= 5'd0;
      dec_addr   <= 5'd0;
      dec_wrdata <= 8'd0;
      dec_wren   <= 1'b0;
      new_char   <= 1'b0;
`ifdef RC4_EARLY_REJECT_EN
      rej_pend   <= 1'b0;
      reject_q   <= 1'b0;
`endif
    end else begin
      // strobes default low so they are single-cycle and cleared on abort
      s_wren   <= 1'b0;
      dec_wren <= 1'b0;
      new_char <= 1'b0;
`ifdef RC4_EARLY_REJECT_EN
      reject_q <= 1'b0;
`endif
      if (start_over) begin
        i <= 8'd0;
        j <= 8'd0;
        k <= '0;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (start) begin
              i <= 8'd0;
              j <= 8'd0;
              k <= '0;
            end
          end
          INC_I: begin
            i      <= i + 8'd1;
            s_addr <= i + 8'd1;
          end
          READ_SI: begin
            si     <= s_rddata;
            j      <= j + s_rddata;
            s_addr <= j + s_rddata;
          end
          READ_SJ: sj <= s_rddata;
          WR_I: begin
            s_addr   <= i;
            s_wrdata <= sj;
            s_wren   <= 1'b1;
          end
          WR_J: begin
            s_addr   <= j;
            s_wrdata <= si;
            s_wren   <= 1'b1;
          end
          ADDR_F: begin
            s_addr   <= si + sj;
            rom_addr <= 5'(k);
          end
          READ_F: begin
            f   <= s_rddata;
            enc <= rom_rddata;
          end
          WR_DEC: begin
            dec_addr   <= 5'(k);
            dec_wrdata <= dec_byte;
            dec_wren   <= 1'b1;
            char_out   <= dec_byte;
`ifdef RC4_EARLY_REJECT_EN
            rej_pend   <= char_bad;
`endif
          end
          EMIT: begin
`ifdef RC4_EARLY_REJECT_EN
            reject_q <= rej_pend;
            new_char <= !rej_pend;
            rej_pend <= 1'b0;
`else
            new_char <= 1'b1;
`endif
          end
          WAIT_ACK: if (char_ack) k <= k + 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_decrypt_loop.sv
// Directed bench for rc4_decrypt_loop with behavioural S memory, ROM and
// decrypted RAM; expected characters come from constants and an RC4 model.
module tb_rc4_decrypt_loop;

  logic       clok = 1'b0;
  logic       resetm;
  logic       start;
  logic       start_over;
  logic       char_ack;
  logic [7:0] s_addr;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] s_rddata;
  logic [4:0] rom_addr;
  logic [7:0] rom_rddata;
  logic [4:0] dec_addr;
  logic [7:0] dec_wrdata;
  logic       dec_wren;
  logic [7:0] char_out;
  logic       new_char;
  logic [5:0] char_count;
  logic       busy;
  logic       done;
  logic       reject;

  logic [7:0] smem   [256];
  logic [7:0] rom    [32];
  logic [7:0] decmem [32];
  logic [7:0] plain  [32];
  logic       load_s = 1'b0;
  int         s_wr_cnt = 0;
  int         dec_wr_cnt = 0;
  int         new_char_cnt = 0;
  int         passes = 0;
  int         total = 0;

  logic [53:0] outvec;
  assign outvec = {busy, done, new_char, s_wren, dec_wren, reject, char_count,
                   s_addr, rom_addr, dec_addr, char_out, s_wrdata, dec_wrdata};

  rc4_decrypt_loop #(.MSG_LEN(32), .K_W(6)) dut (
    .clok(clok), .resetm(resetm), .start(start), .start_over(start_over),
    .char_ack(char_ack), .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren),
    .s_rddata(s_rddata), .rom_addr(rom_addr), .rom_rddata(rom_rddata),
    .dec_addr(dec_addr), .dec_wrdata(dec_wrdata), .dec_wren(dec_wren),
    .char_out(char_out), .new_char(new_char), .char_count(char_count),
    .busy(busy), .done(done), .reject(reject)
  );

  always #5 clok = ~clok;

  always @(posedge clok) begin
    if (load_s) begin
      for (int x = 0; x < 256; x++) smem[x] <= 8'(x);
    end else if (s_wren) begin
      smem[s_addr] <= s_wrdata;
      s_wr_cnt <= s_wr_cnt + 1;
    end
    s_rddata   <= smem[s_addr];
    rom_rddata <= rom[rom_addr];
    if (dec_wren) begin
      decmem[dec_addr] <= dec_wrdata;
      dec_wr_cnt <= dec_wr_cnt + 1;
    end
    if (new_char) new_char_cnt <= new_char_cnt + 1;
  end

  task automatic tick();
    @(posedge clok);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(new_char || reject) && n < 40);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_ack();
    char_ack = 1'b1;
    tick();
    char_ack = 1'b0;
  endtask

  task automatic reload_s();
    load_s = 1'b1;
    tick();
    load_s = 1'b0;
  endtask

  initial begin
    logic [7:0] ms [256];
    logic [7:0] ks [32];
    logic [7:0] t;
    int mi, mj, n, snap_s, snap_d, snap_n;

    for (int x = 0; x < 256; x++) ms[x] = 8'(x);
    mi = 0;
    mj = 0;
    for (int q = 0; q < 32; q++) begin
      mi = (mi + 1) & 255;
      mj = (mj + int'(ms[mi])) & 255;
      t = ms[mi];
      ms[mi] = ms[mj];
      ms[mj] = t;
      ks[q] = ms[(int'(ms[mi]) + int'(ms[mj])) & 255];
      plain[q] = 8'(8'h61 + (q % 26));
      rom[q] = plain[q] ^ ks[q];
    end
    rom[0] = 8'h63;
    rom[1] = 8'h67;
    rom[2] = 8'h64;

    resetm = 1'b1;
    start = 1'b0;
    start_over = 1'b0;
    char_ack = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'(outvec), 64'd0);
    start = 1'b1;
    tick();
    tick();
    check("start_ignored_in_reset", {62'd0, busy, done}, 64'd0);
    start = 1'b0;
    resetm = 1'b0;
    reload_s();
    check("idle_after_reset", {62'd0, busy, done}, 64'd0);

    // full message with identity S, ack every character
    do_start();
    check("busy_after_start", 64'(busy), 64'd1);
    for (int q = 0; q < 32; q++) begin
      wait_pulse(n);
      check(q == 0 ? "first_latency_from_start" : "char_latency",
            64'(q == 0 ? n + 1 : n), q == 0 ? 64'd13 : 64'd12);
      check("new_char_pulse", 64'(new_char), 64'd1);
      check("char_out", 64'(char_out), 64'(plain[q]));
      check("char_count", 64'(char_count), 64'(q));
      check("dec_ram", 64'(decmem[q]), 64'(plain[q]));
      if (q == 1) begin
        check("s2_after_swap", 64'(smem[2]), 64'h03);
        check("s3_after_swap", 64'(smem[3]), 64'h02);
      end
      do_ack();
      check("new_char_width", 64'(new_char), 64'd0);
      if (q < 31) begin
        check("char_count_after_ack", 64'(char_count), 64'(q + 1));
        check("busy_mid_msg", {62'd0, busy, done}, 64'd2);
      end else begin
        check("done_after_last", {62'd0, busy, done}, 64'd1);
      end
    end
    check("new_char_count", 64'(new_char_cnt), 64'd32);
    tick();
    check("done_holds", 64'(done), 64'd1);

    // abort at k=5, then restart from DONE/IDLE
    reload_s();
    do_start();
    check("left_done_on_start", {62'd0, busy, done}, 64'd2);
    for (int q = 0; q < 5; q++) begin
      wait_pulse(n);
      do_ack();
    end
    wait_pulse(n);
    check("abort_k5_count", 64'(char_count), 64'd5);
    check("abort_k5_char", 64'(char_out), 64'(plain[5]));
    start_over = 1'b1;
    tick();
    start_over = 1'b0;
    check("abort_idle", {62'd0, busy, done}, 64'd0);
    check("abort_char_count", 64'(char_count), 64'd0);
    snap_s = s_wr_cnt;
    snap_d = dec_wr_cnt;
    snap_n = new_char_cnt;
    repeat (20) tick();
    check("no_dec_wr_after_abort", 64'(dec_wr_cnt), 64'(snap_d));
    check("no_s_wr_after_abort", 64'(s_wr_cnt), 64'(snap_s));
    check("no_new_char_after_abort", 64'(new_char_cnt), 64'(snap_n));
    reload_s();
    do_start();
    wait_pulse(n);
    check("restart_latency", 64'(n), 64'd12);
    check("restart_char", 64'(char_out), 64'h61);
    check("restart_count", 64'(char_count), 64'd0);

    // char_ack and start_over together at k=1
    do_ack();
    wait_pulse(n);
    check("pre_collide_count", 64'(char_count), 64'd1);
    char_ack = 1'b1;
    start_over = 1'b1;
    tick();
    char_ack = 1'b0;
    start_over = 1'b0;
    check("collide_idle", {62'd0, busy, done}, 64'd0);
    check("collide_count", 64'(char_count), 64'd0);
    repeat (5) tick();
    check("collide_no_done", {62'd0, busy, done}, 64'd0);

    // reset asserted while in WR_I
    reload_s();
    do_start();
    repeat (5) tick();
    snap_s = s_wr_cnt;
    resetm = 1'b1;
    start = 1'b1;
    tick();
    check("midchar_reset_outputs", 64'(outvec), 64'd0);
    repeat (2) tick();
    check("reset_holds_idle", {62'd0, busy, s_wren}, 64'd0);
    resetm = 1'b0;
    start = 1'b0;
    tick();
    check("idle_after_midreset", 64'(busy), 64'd0);
    check("no_s_wr_after_reset", 64'(s_wr_cnt), 64'(snap_s));
    reload_s();
    do_start();
    wait_pulse(n);
    check("post_reset_char", 64'(char_out), 64'h61);

`ifdef RC4_EARLY_REJECT_EN
    resetm = 1'b1;
    tick();
    resetm = 1'b0;
    rom[0] = 8'h00;
    reload_s();
    do_start();
    wait_pulse(n);
    check("reject_latency", 64'(n), 64'd12);
    check("reject_pulse", {62'd0, reject, new_char}, 64'd2);
    check("reject_idle", 64'(busy), 64'd0);
    check("reject_dec_ram", 64'(decmem[0]), 64'h02);
    tick();
    check("reject_width", {62'd0, reject, busy}, 64'd0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
